monolith_perm_stream: RTL and testbench
=======================================

// Module: monolith_perm_stream
// PURPOSE
//  Streaming front-end for the Monolith permutation. Deserialises STATE_WORDS field elements
//  from a valid/ready input stream and runs the round core NUM_ROUNDS times on that state.
//  Then serialises the result onto a valid/ready output stream with a last marker.
//  Sits between the host word interface and monolith_round. Loses no words and never double-issues.
// PARAMETERS
//  WORD_W      31          width of one field element (Mersenne-31)
//  STATE_WORDS 16          elements per permutation state (8 or 16 supported)
//  NUM_ROUNDS  6           round-core invocations per permutation (>=1)
//  MODULUS     2**31-1     field prime; input canonicity check
// PORTS
//  clk         in   1                 rising-edge clock
//  reset_n     in   1                 synchronous, active-low reset
//  in_data     in   WORD_W            input element
//  in_valid    in   1                 in_data valid
//  in_ready    out  1                 block accepts in_data this cycle
//  out_data    out  WORD_W            output element
//  out_valid   out  1                 out_data valid
//  out_ready   in   1                 sink accepts out_data this cycle
//  out_last    out  1                 marks element STATE_WORDS-1 of a result
//  busy        out  1                 high in RUN state
//  err_noncanon out 1                 sticky: a loaded element was >= MODULUS
//  clr_err     in   1                 clears err_noncanon (one-cycle pulse)
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): state=LOAD and counters=0. in_ready=0 for that cycle,
//    then 1 in LOAD. out_valid=0, out_last=0, out_data=0, busy=0, err_noncanon=0.
//    Reset aborts any LOAD/RUN/UNLOAD; partial state is discarded, and core_start is never left high.
//  - FSM LOAD -> RUN -> UNLOAD -> LOAD.
//  - LOAD: in_ready=1. A word transfers when in_valid&in_ready. It is written to state[wcnt] and wcnt++.
//    On the transfer with wcnt==STATE_WORDS-1: wcnt=0, go to RUN. All STATE_WORDS words are captured.
//  - Non-canonical input (in_data >= MODULUS) is stored as in_data-MODULUS. err_noncanon is set.
//    If clr_err and a new error occur in the same cycle, the set wins.
//  - RUN: in_ready=0, busy=1. core_start pulses 1 cycle with core_state_in=state.
//    On core_done, state<=core_state_out and rcnt++.
//    If rcnt==NUM_ROUNDS-1: rcnt=0, go to UNLOAD; otherwise re-pulse core_start the next cycle.
//    core_done without a prior start is ignored.
//  - UNLOAD: out_valid=1, out_data=state[ocnt] (registered), out_last=(ocnt==STATE_WORDS-1).
//    On out_valid&out_ready: ocnt++. out_data holds stable while out_ready=0.
//    After the last word transfers: out_valid=0, state=LOAD, in_ready=1 next cycle.
//    No overlap between LOAD and UNLOAD; input backpressures throughout RUN/UNLOAD.
//  - Latency: last input transfer to first out_valid = NUM_ROUNDS*(L_core+1)+1 cycles (L_core = core latency).
//  - Counter widths are $clog2(STATE_WORDS)+1 and $clog2(NUM_ROUNDS)+1. No wrap is relied on;
//    terminal compares are explicit.
//  - Throughput: one word per cycle in LOAD/UNLOAD with a source/sink that never stalls.
// STRUCTURE
//  - monolith_pkg: WORD_W, MODULUS, STATE_WORDS defaults; typedef word_t = logic[WORD_W-1:0];
//    typedef state_t = word_t[STATE_WORDS]; enum {LOAD,RUN,UNLOAD} stream_state_e.
//  - One sub-module, monolith_round (existing core). Interface used: clk, reset_n, core_start,
//    core_state_in, core_state_out, core_done.
//  - Wrapper body: FSM, three counters, state register file, canonicity reducer (combinational).
// TESTING
//  1 Load words 0..15, stall-free, NUM_ROUNDS=1 -> exactly 16 out transfers = golden model(0..15);
//    out_last only on 16th.
//  2 Random in_valid (50%) and out_ready (30%) gaps -> output identical to test 1; out_data stable
//    during every stall.
//  3 Word 5 = 0x7FFFFFFF -> stored as 0, err_noncanon=1 until clr_err pulse; result = golden(with 0).
//  4 reset_n low for 1 cycle after 7 words loaded -> next 16 words form a fresh state;
//    no output from partial load.
//  5 reset_n low mid-RUN and mid-UNLOAD (after 3 outputs) -> out_valid=0, busy=0 next cycle;
//    next permutation correct.
//  6 NUM_ROUNDS=6, STATE_WORDS=8 build -> 6 core_start pulses per permutation; result matches
//    6-round model.

Source files
------------

// File: rtl/monolith_pkg.sv
// Shared types, constants and field helpers for the Monolith streaming front-end.
// Arithmetic is over the Mersenne-31 field (p = 2^31-1). mod_sq folds the
// high half onto the low half, which relies on 2^31 == 1 (mod p).
package monolith_pkg;

   localparam int                WORD_W              = 31;
   localparam logic [WORD_W-1:0] MODULUS             = 31'h7FFF_FFFF;
   localparam int                DEFAULT_STATE_WORDS = 16;
   localparam int                DEFAULT_NUM_ROUNDS  = 6;

   typedef logic [WORD_W-1:0] word_t;
   typedef word_t state_t [DEFAULT_STATE_WORDS];

   typedef enum logic [1:0] {LOAD, RUN, UNLOAD} stream_state_e;

   // Bring a value below 2*MODULUS into canonical range.
   function automatic word_t mod_reduce(input logic [WORD_W:0] s);
      return WORD_W'((s >= {1'b0, MODULUS}) ? s - {1'b0, MODULUS} : s);
   endfunction

   function automatic word_t mod_add(input word_t a, input word_t b);
      return mod_reduce({1'b0, a} + {1'b0, b});
   endfunction

   // Two Mersenne folds: the first leaves < 2^32, the second leaves <= p+1.
   function automatic word_t mod_sq(input word_t a);
      logic [2*WORD_W-1:0] prod;
      logic [WORD_W:0]     fold;
      prod = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, a};
      fold = {1'b0, prod[WORD_W-1:0]} + {1'b0, prod[2*WORD_W-1:WORD_W]};
      return mod_reduce({1'b0, fold[WORD_W-1:0]} + {{WORD_W{1'b0}}, fold[WORD_W]});
   endfunction

endpackage

// File: rtl/monolith_round.sv
// Monolith round core: one round per core_start, result one cycle later.
// Each lane i becomes x[i] + x[i-1]^2 + (i+1) (mod p), lane 0 taking the
// last lane as its neighbour.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   core_start       1-cycle request; core_state_in sampled on the same edge
//   core_state_in    state to transform
//   core_state_out   round result, valid while core_done is high and after
//   core_done        1-cycle pulse, one cycle after core_start
module monolith_round
   import monolith_pkg::*;
#(
   parameter int STATE_WORDS = DEFAULT_STATE_WORDS
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         core_start,
   input  word_t [STATE_WORDS-1:0]      core_state_in,
   output word_t [STATE_WORDS-1:0]      core_state_out,
   output logic                         core_done
);

   word_t [STATE_WORDS-1:0] nxt;

   for (genvar i = 0; i < STATE_WORDS; i++) begin : g_lane
      localparam int PREV = (i + STATE_WORDS - 1) % STATE_WORDS;
      assign nxt[i] = mod_add(mod_add(core_state_in[i], mod_sq(core_state_in[PREV])),
                              WORD_W'(i + 1));
   end

   // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (!reset_n) core_done <= 1'b0;
      else          core_done <= core_start;
   end

   // NOTE: wide data registers carry no reset; only the control bit that qualifies them does.
   always_ff @(posedge clk) begin
      if (core_start) core_state_out <= nxt;
   end

endmodule

// File: rtl/monolith_perm_stream.sv
// Streaming front-end for the Monolith permutation: collects STATE_WORDS
// elements from a valid/ready stream, runs monolith_round NUM_ROUNDS times,
// then streams the result out with a last marker. Load and unload never
// overlap; input is backpressured during RUN and UNLOAD.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   in_data/in_valid/in_ready     input element stream
//   out_data/out_valid/out_ready  output element stream (registered)
//   out_last                marks the final element of a result
//   busy                    high while the round core is being iterated
//   err_noncanon            sticky flag: some loaded element was >= MODULUS
//   clr_err                 clears err_noncanon (a new error in the same cycle wins)
// WORD_W and MODULUS are fixed by the package because the field arithmetic is Mersenne-31 specific.
module monolith_perm_stream
   import monolith_pkg::*;
#(
   parameter int STATE_WORDS = DEFAULT_STATE_WORDS,
   parameter int NUM_ROUNDS  = DEFAULT_NUM_ROUNDS
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              err_noncanon,
   input  logic              clr_err
);

   localparam int IW = $clog2(STATE_WORDS);
   localparam int CW = IW + 1;
   localparam int RW = $clog2(NUM_ROUNDS) + 1;
   localparam logic [CW-1:0] LAST_W = CW'(STATE_WORDS - 1);
   localparam logic [RW-1:0] LAST_R = RW'(NUM_ROUNDS - 1);

   stream_state_e           st, st_nxt;
   logic [CW-1:0]           wcnt, ocnt, ocnt_inc;
   logic [RW-1:0]           rcnt;
   word_t [STATE_WORDS-1:0] regs, core_out;
   word_t                   in_canon;
   logic                    core_start, core_done, core_pending;
   logic                    in_fire, out_fire, round_done, last_round, in_bad;

   assign in_bad     = in_data >= MODULUS;
   assign in_canon   = in_bad ? in_data - MODULUS : in_data;
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;
   // A done only counts when this block has a request outstanding.
   assign round_done = (st == RUN) & core_pending & core_done;
   assign last_round = round_done & (rcnt == LAST_R);
   assign ocnt_inc   = ocnt + CW'(1);

   monolith_round #(.STATE_WORDS(STATE_WORDS)) u_round (
      .clk            (clk),
      .reset_n        (reset_n),
      .core_start     (core_start),
      .core_state_in  (regs),
      .core_state_out (core_out),
      .core_done      (core_done)
   );

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset_n) st <= LOAD;
      else          st <= st_nxt;
   end

   // FSM: next state
   always_comb begin
      // NOTE: defaulting every output first keeps this block free of inferred latches.
      st_nxt = st;
      case (st)
         LOAD:    if (in_fire && wcnt == LAST_W)  st_nxt = RUN;
         RUN:     if (last_round)                 st_nxt = UNLOAD;
         UNLOAD:  if (out_fire && ocnt == LAST_W) st_nxt = LOAD;
         default:                                 st_nxt = LOAD;
      endcase
   end

   // FSM: outputs. Gated by reset_n so nothing is accepted or started in a reset cycle.
   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      core_start = 1'b0;
      case (st)
         LOAD:    in_ready = reset_n;
         RUN: begin
            busy       = 1'b1;
            core_start = reset_n & ~core_pending;
         end
         default: ;
      endcase
   end

   // Counters, handshake state and the registered output stage.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wcnt         <= '0;
         rcnt         <= '0;
         ocnt         <= '0;
         core_pending <= 1'b0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_data     <= '0;
         err_noncanon <= 1'b0;
      end else begin
         if (in_fire) wcnt <= (wcnt == LAST_W) ? '0 : wcnt + CW'(1);

         if (core_start)      core_pending <= 1'b1;
         else if (round_done) core_pending <= 1'b0;

         if (round_done) rcnt <= last_round ? '0 : rcnt + RW'(1);

         if (last_round) begin
            // First result word comes straight from the core; later ones from regs.
            out_valid <= 1'b1;
            out_data  <= core_out[0];
            out_last  <= (STATE_WORDS == 1);
            ocnt      <= '0;
         end else if (out_fire) begin
            if (ocnt == LAST_W) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               out_data  <= '0;
               ocnt      <= '0;
            end else begin
               ocnt     <= ocnt_inc;
               out_data <= regs[ocnt_inc[IW-1:0]];
               out_last <= (ocnt_inc == LAST_W);
            end
         end

         if (in_fire && in_bad) err_noncanon <= 1'b1;
         else if (clr_err)      err_noncanon <= 1'b0;
      end
   end

   // State register file; a reset simply restarts wcnt, discarding partial loads.
   always_ff @(posedge clk) begin
      if (in_fire)         regs[wcnt[IW-1:0]] <= in_canon;
      else if (round_done) regs               <= core_out;
   end

endmodule

// File: tb/tb_monolith_perm_stream.sv
module tb_monolith_perm_stream;

   localparam longint P = 64'd2147483647;

   logic        clk = 1'b0;
   logic        reset_n, sel, in_valid, out_ready, clr_err;
   logic [30:0] in_data;

   logic        a_in_ready, a_out_valid, a_out_last, a_busy, a_err;
   logic        b_in_ready, b_out_valid, b_out_last, b_busy, b_err;
   logic [30:0] a_out_data, b_out_data;

   logic        in_ready, out_valid, out_last, busy, err;
   logic [30:0] out_data;

   int     n_pass = 0;
   int     n_total = 0;
   int     nw = 16;
   int     start_cnt = 0;
   longint vec [16];
   longint exp_q [16];

   always #5 clk = ~clk;

   // sel picks which build the shared stimulus/observation signals talk to.
   assign in_ready  = sel ? b_in_ready  : a_in_ready;
   assign out_valid = sel ? b_out_valid : a_out_valid;
   assign out_data  = sel ? b_out_data  : a_out_data;
   assign out_last  = sel ? b_out_last  : a_out_last;
   assign busy      = sel ? b_busy      : a_busy;
   assign err       = sel ? b_err       : a_err;

   monolith_perm_stream #(.STATE_WORDS(16), .NUM_ROUNDS(1)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid & ~sel),
      .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(out_ready & ~sel), .out_last(a_out_last), .busy(a_busy),
      .err_noncanon(a_err), .clr_err(clr_err)
   );

   monolith_perm_stream #(.STATE_WORDS(8), .NUM_ROUNDS(6)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid & sel),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(out_ready & sel), .out_last(b_out_last), .busy(b_busy),
      .err_noncanon(b_err), .clr_err(clr_err)
   );

   always @(posedge clk) if (dut8.core_start) start_cnt <= start_cnt + 1;

   // Reference permutation: canonicalise, then apply the round formula 'rounds' times.
   function automatic void model_perm(input int n, input int rounds);
      longint cur [16];
      longint nx [16];
      longint a;
      for (int i = 0; i < n; i++) cur[i] = (vec[i] >= P) ? vec[i] - P : vec[i];
      for (int r = 0; r < rounds; r++) begin
         for (int i = 0; i < n; i++) begin
            a     = cur[(i + n - 1) % n];
            nx[i] = (cur[i] + (a * a) % P + i + 1) % P;
         end
         for (int i = 0; i < n; i++) cur[i] = nx[i];
      end
      for (int i = 0; i < n; i++) exp_q[i] = cur[i];
   endfunction

   // Inputs 0..15 through one round give x^2+2 for lanes 1..15 and 0+15^2+1 for lane 0.
   task automatic set_counting_vec();
      for (int i = 0; i < 16; i++) begin
         vec[i]   = i;
         exp_q[i] = (i == 0) ? 226 : i * i + 2;
      end
   endtask

   task automatic load(input int n, input bit gaps, input int clr_idx);
      int idx = 0;
      int guard = 0;
      while (idx < n && guard < 3000) begin
         @(negedge clk);
         guard++;
         in_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
         in_data  = 31'(vec[idx]);
         clr_err  = in_valid && (idx == clr_idx);
         if (in_valid && in_ready) idx++;
      end
      n_total++;
      if (idx != n) $display("FAIL load_count: got %0d words want %0d", idx, n);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      clr_err  = 1'b0;
   endtask

   task automatic unload(input int n_take, input int stall_pct);
      int          cnt = 0;
      int          guard = 0;
      bit          was_stall = 1'b0;
      logic [30:0] held = '0;
      while (cnt < n_take && guard < 3000) begin
         @(negedge clk);
         guard++;
         out_ready = ($urandom_range(99, 0) >= stall_pct);
         if (out_valid) begin
            if (was_stall) begin
               n_total++;
               if (out_data !== held) $display("FAIL hold_stable[%0d]: got %h want %h", cnt, out_data, held);
               else n_pass++;
            end
            if (out_ready) begin
               n_total++;
               if (out_data !== 31'(exp_q[cnt]))
                  $display("FAIL out_data[%0d]: got %h want %h", cnt, out_data, 31'(exp_q[cnt]));
               else n_pass++;
               n_total++;
               if (out_last !== (cnt == nw - 1))
                  $display("FAIL out_last[%0d]: got %b want %b", cnt, out_last, (cnt == nw - 1));
               else n_pass++;
               cnt++;
               was_stall = 1'b0;
            end else begin
               was_stall = 1'b1;
               held      = out_data;
            end
         end
      end
      n_total++;
      if (cnt != n_take) $display("FAIL out_count: got %0d words want %0d", cnt, n_take);
      else n_pass++;
      @(negedge clk);
      out_ready = 1'b0;
      if (n_take == nw) begin
         n_total++;
         if (out_valid !== 1'b0) $display("FAIL valid_after_last: got %b want 0", out_valid);
         else n_pass++;
         n_total++;
         if (in_ready !== 1'b1) $display("FAIL ready_after_unload: got %b want 1", in_ready);
         else n_pass++;
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready);
      else n_pass++;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
      else n_pass++;
      n_total++;
      if ({out_valid, out_last, busy, err} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {out_valid, out_last, busy, err});
      else n_pass++;
      n_total++;
      if (out_data !== 31'd0) $display("FAIL reset_out_data: got %h want 0", out_data);
      else n_pass++;
      reset_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL load_in_ready: got %b want 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_stream_basic();
      set_counting_vec();
      load(16, 1'b0, -1);
      n_total++;
      if (busy !== 1'b1) $display("FAIL run_busy: got %b want 1", busy);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL run_in_ready: got %b want 0", in_ready);
      else n_pass++;
      unload(16, 0);
   endtask

   task automatic test_gaps();
      set_counting_vec();
      load(16, 1'b1, -1);
      unload(16, 30);
   endtask

   task automatic test_noncanon();
      set_counting_vec();
      vec[5] = P;
      model_perm(16, 1);
      load(16, 1'b0, -1);
      n_total++;
      if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err);
      else n_pass++;
      unload(16, 0);
      n_total++;
      if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
      else n_pass++;
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      n_total++;
      if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err);
      else n_pass++;
      // Clear coinciding with the bad word: the set must win.
      load(16, 1'b0, 5);
      n_total++;
      if (err !== 1'b1) $display("FAIL err_set_wins: got %b want 1", err);
      else n_pass++;
      unload(16, 0);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 16; i++) vec[i] = 100 + i;
      load(7, 1'b0, -1);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL partial_no_out: got %b want 0", out_valid);
      else n_pass++;
      pulse_reset();
      for (int i = 0; i < 16; i++) vec[i] = 1000 + 3 * i;
      model_perm(16, 1);
      load(16, 1'b0, -1);
      unload(16, 0);
   endtask

   task automatic test_reset_mid_run_unload();
      for (int i = 0; i < 16; i++) vec[i] = 50000 + 7 * i;
      load(16, 1'b0, -1);
      pulse_reset();
      for (int i = 0; i < 16; i++) vec[i] = P - 1 - i;
      model_perm(16, 1);
      load(16, 1'b0, -1);
      unload(3, 0);
      pulse_reset();
      for (int i = 0; i < 16; i++) vec[i] = 12345 * (i + 1);
      model_perm(16, 1);
      load(16, 1'b0, -1);
      unload(16, 10);
   endtask

   task automatic test_rounds6_sw8();
      int starts_before;
      sel = 1'b1;
      nw  = 8;
      for (int i = 0; i < 8; i++) vec[i] = 7 * i + 1;
      vec[7] = P - 1;
      model_perm(8, 6);
      starts_before = start_cnt;
      load(8, 1'b0, -1);
      unload(8, 20);
      n_total++;
      if (start_cnt - starts_before != 6)
         $display("FAIL core_starts: got %0d want 6", start_cnt - starts_before);
      else n_pass++;
      sel = 1'b0;
      nw  = 16;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      sel       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clr_err   = 1'b0;
      test_reset();
      test_stream_basic();
      test_gaps();
      test_noncanon();
      test_reset_mid_load();
      test_reset_mid_run_unload();
      test_rounds6_sw8();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
